dcache_ctrl: RTL and testbench

- Direct-mapped, write-back data cache between the ALU and the word-wide data memory.
- The ALU RESULT drives ADDRESS for loads and stores.
- Register-file write data drives WRITEDATA.
- BUSYWAIT stalls the PC and register file until the access completes.
- 8 blocks x 4 bytes; the memory side transfers one 32-bit block per access.

---
 rtl/dcache_ctrl.sv | 145 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache (8 lines x 4 bytes) between the CPU and a block-wide memory.
// Optional hit/miss statistics counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int NBLOCKS = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_e;

  state_e             state_q, state_d;
  logic [NBLOCKS-1:0] valid_q, dirty_q;
  logic [2:0]         tag_q  [NBLOCKS];
  logic [31:0]        data_q [NBLOCKS];
  logic [7:0]         readdata_q;

  logic [2:0]  tag, idx;
  logic [1:0]  off;
  logic        req, rd_req, hit;
  logic [31:0] line;
  logic [7:0]  sel_byte;
  logic        rd_hit_en, wr_hit_en, fill_en, miss_ev;

  assign tag      = ADDRESS[7:5];
  assign idx      = ADDRESS[4:2];
  assign off      = ADDRESS[1:0];
  // Simultaneous READ and WRITE is treated as a plain load.
  assign rd_req   = READ;
  assign req      = READ | WRITE;
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign line     = data_q[idx];
  assign sel_byte = line[{off, 3'b000} +: 8];

  always_comb begin
    state_d       = state_q;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    READDATA      = readdata_q;
    rd_hit_en     = 1'b0;
    wr_hit_en     = 1'b0;
    fill_en       = 1'b0;
    miss_ev       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (rd_req) begin
              READDATA  = sel_byte;
              rd_hit_en = 1'b1;
            end else begin
              wr_hit_en = 1'b1;
            end
          end else begin
            BUSYWAIT = 1'b1;
            miss_ev  = 1'b1;
            state_d  = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[idx], idx};
        MEM_WRITEDATA = line;
        if (!MEM_BUSYWAIT) state_d = FETCH;
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag, idx};
        if (!MEM_BUSYWAIT) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_hit_en) readdata_q <= sel_byte;
      if (wr_hit_en) dirty_q[idx] <= 1'b1;
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Line payload carries no reset; the valid bits alone decide whether it is used.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      data_q[idx] <= MEM_READDATA;
      tag_q[idx]  <= tag;
    end else if (wr_hit_en) begin
      data_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if ((rd_hit_en || wr_hit_en) && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (miss_ev && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: table of cache accesses against a latency-programmable block memory,
// plus hand sequences for reset and reset-mid-fetch.
module tb_dcache_ctrl;

  logic        CLK, RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

  dcache_ctrl dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Block memory model: a transfer finishes after 'lat' strobe cycles.
  logic [31:0] mem [64];
  int          cnt;
  int          lat;
  logic        mem_init;

  assign MEM_BUSYWAIT = !((MEM_READ || MEM_WRITE) && (cnt == lat - 1));
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
      mem[6'h09] <= 32'hDDCCBBAA;
      mem[6'h29] <= 32'h44332211;
      mem[6'h01] <= 32'h88776655;
      mem[6'h3F] <= 32'hA1B2C3D4;
      mem[6'h11] <= 32'h0BADF00D;
      cnt <= 0;
    end else if (MEM_READ || MEM_WRITE) begin
      if (cnt == lat - 1) begin
        cnt <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wd;
    int          lat;
    int          stall;
    logic [7:0]  rdata;
    logic        wb;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ft;
    logic [5:0]  ft_addr;
  } vec_t;

  vec_t tbl [17];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_acc(input string nm, input vec_t v);
    int          stalls;
    logic        wb_seen, ft_seen;
    logic [5:0]  wb_a, ft_a;
    logic [31:0] wb_d;
    logic [7:0]  rdv;
    stalls = 0; wb_seen = 0; ft_seen = 0; wb_a = '0; ft_a = '0; wb_d = '0;
    lat       = v.lat;
    READ      = v.rd;
    WRITE     = v.wr;
    ADDRESS   = v.addr;
    WRITEDATA = v.wd;
    #1;
    while (BUSYWAIT === 1'b1 && stalls < 200) begin
      if (MEM_WRITE && !wb_seen) begin wb_seen = 1; wb_a = MEM_ADDRESS; wb_d = MEM_WRITEDATA; end
      if (MEM_READ && !ft_seen) begin ft_seen = 1; ft_a = MEM_ADDRESS; end
      @(posedge CLK);
      @(negedge CLK);
      #1;
      stalls++;
    end
    rdv = READDATA;
    @(posedge CLK);
    @(negedge CLK);
    READ  = 1'b0;
    WRITE = 1'b0;
    #1;
    chk({nm, "_stall"}, 32'(stalls), 32'(v.stall));
    chk({nm, "_wb_seen"}, 32'(wb_seen), 32'(v.wb));
    chk({nm, "_ft_seen"}, 32'(ft_seen), 32'(v.ft));
    if (v.wb) begin
      chk({nm, "_wb_addr"}, 32'(wb_a), 32'(v.wb_addr));
      chk({nm, "_wb_data"}, wb_d, v.wb_data);
    end
    if (v.ft) chk({nm, "_ft_addr"}, 32'(ft_a), 32'(v.ft_addr));
    if (v.rd) begin
      chk({nm, "_rdata"}, 32'(rdv), 32'(v.rdata));
      chk({nm, "_hold"}, 32'(READDATA), 32'(v.rdata));
    end
    chk({nm, "_idle_strobes"}, 32'({MEM_READ, MEM_WRITE}), 32'd0);
  endtask

  initial begin
    //         rd wr addr   wd     lat stall rdata  wb wb_a   wb_d          ft ft_a
    tbl[0]  = '{1, 0, 8'h25, 8'h00, 5, 6,  8'hBB, 0, 6'h00, 32'h0,        1, 6'h09};
    tbl[1]  = '{1, 0, 8'h27, 8'h00, 5, 0,  8'hDD, 0, 6'h00, 32'h0,        0, 6'h00};
    tbl[2]  = '{0, 1, 8'h24, 8'h5A, 5, 0,  8'h00, 0, 6'h00, 32'h0,        0, 6'h00};
    tbl[3]  = '{1, 0, 8'h24, 8'h00, 5, 0,  8'h5A, 0, 6'h00, 32'h0,        0, 6'h00};
    tbl[4]  = '{1, 0, 8'hA4, 8'h00, 5, 11, 8'h11, 1, 6'h09, 32'hDDCCBB5A, 1, 6'h29};
    tbl[5]  = '{1, 0, 8'h25, 8'h00, 5, 6,  8'hBB, 0, 6'h00, 32'h0,        1, 6'h09};
    tbl[6]  = '{1, 0, 8'h04, 8'h00, 1, 2,  8'h55, 0, 6'h00, 32'h0,        1, 6'h01};
    tbl[7]  = '{1, 0, 8'h07, 8'h00, 5, 0,  8'h88, 0, 6'h00, 32'h0,        0, 6'h00};
    tbl[8]  = '{0, 1, 8'h3F, 8'hC3, 5, 6,  8'h00, 0, 6'h00, 32'h0,        1, 6'h0F};
    tbl[9]  = '{1, 0, 8'h3F, 8'h00, 5, 0,  8'hC3, 0, 6'h00, 32'h0,        0, 6'h00};
    tbl[10] = '{1, 0, 8'h3C, 8'h00, 5, 0,  8'h00, 0, 6'h00, 32'h0,        0, 6'h00};
    tbl[11] = '{1, 1, 8'h3F, 8'hFF, 5, 0,  8'hC3, 0, 6'h00, 32'h0,        0, 6'h00};
    tbl[12] = '{1, 0, 8'h3F, 8'h00, 5, 0,  8'hC3, 0, 6'h00, 32'h0,        0, 6'h00};
    tbl[13] = '{1, 0, 8'hFF, 8'h00, 3, 7,  8'hA1, 1, 6'h0F, 32'hC3000000, 1, 6'h3F};
    tbl[14] = '{1, 0, 8'h3F, 8'h00, 5, 6,  8'hC3, 0, 6'h00, 32'h0,        1, 6'h0F};
    tbl[15] = '{0, 1, 8'h3E, 8'h77, 5, 0,  8'h00, 0, 6'h00, 32'h0,        0, 6'h00};
    tbl[16] = '{1, 0, 8'h3E, 8'h00, 5, 0,  8'h77, 0, 6'h00, 32'h0,        0, 6'h00};

    RESET = 1'b1; mem_init = 1'b1; lat = 5;
    READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    mem_init = 1'b0;
    RESET    = 1'b0;
    #1;
    chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
    chk("rst_mem_read", 32'(MEM_READ), 32'd0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    chk("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
    chk("rst_mem_writedata", MEM_WRITEDATA, 32'd0);
    chk("rst_readdata", 32'(READDATA), 32'd0);
`ifdef DCACHE_STATS_EN
    chk("rst_hit_count", 32'(HIT_COUNT), 32'd0);
    chk("rst_miss_count", 32'(MISS_COUNT), 32'd0);
`endif

    for (int i = 0; i < 17; i++) do_acc($sformatf("v%0d", i), tbl[i]);

`ifdef DCACHE_STATS_EN
    chk("tbl_hit_count", 32'(HIT_COUNT), 32'd17);
    chk("tbl_miss_count", 32'(MISS_COUNT), 32'd7);
`endif

    // Reset while a fetch is in flight.
    lat = 5; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h45;
    #1;
    chk("mid_idle_busy", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("mid_fetch_strobe", 32'(MEM_READ), 32'd1);
    chk("mid_fetch_addr", 32'(MEM_ADDRESS), 32'h11);
    RESET = 1'b1; READ = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("abort_mem_read", 32'(MEM_READ), 32'd0);
    chk("abort_busywait", 32'(BUSYWAIT), 32'd0);
    chk("abort_mem_address", 32'(MEM_ADDRESS), 32'd0);
    chk("abort_readdata", 32'(READDATA), 32'd0);
`ifdef DCACHE_STATS_EN
    chk("abort_hit_count", 32'(HIT_COUNT), 32'd0);
    chk("abort_miss_count", 32'(MISS_COUNT), 32'd0);
`endif
    RESET = 1'b0;
    do_acc("post_rst_45", '{1, 0, 8'h45, 8'h00, 5, 6, 8'hF0, 0, 6'h00, 32'h0, 1, 6'h11});
    do_acc("post_rst_04", '{1, 0, 8'h04, 8'h00, 5, 6, 8'h55, 0, 6'h00, 32'h0, 1, 6'h01});
`ifdef DCACHE_STATS_EN
    chk("end_hit_count", 32'(HIT_COUNT), 32'd2);
    chk("end_miss_count", 32'(MISS_COUNT), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
